// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/branch decode plus an iterative 16-step MUL/DIV/REM unit.
// Latency: ALU and branch results are combinational; MUL/DIV/REM occupy 18 cycles (issue + 16 steps + result).
// Backpressure: hold_en_o stays high for the first 17 of those cycles so ctrl freezes the upstream registers.
module ex_stage #(
    parameter int DW = 16,
    parameter int AW = 4,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] inst_i,
    input  logic [AW-1:0] inst_addr_i,
    input  logic [DW-1:0] op1_i,
    input  logic [DW-1:0] op2_i,
    input  logic [RW-1:0] rd_addr_i,
    input  logic          reg_wen_i,
    output logic [DW-1:0] rd_data_o,
    output logic [RW-1:0] rd_addr_o,
    output logic          reg_wen_o,
    output logic          jump_en_o,
    output logic [AW-1:0] jump_addr_o,
    output logic          hold_en_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3, OP_OR  = 4'h4,
                           OP_XOR = 4'h5, OP_SLL = 4'h6, OP_SRL = 4'h7, OP_MUL = 4'h8,
                           OP_DIV = 4'h9, OP_REM = 4'hA, OP_BEQ = 4'hB, OP_BNE = 4'hC,
                           OP_JMP = 4'hD;

    state_t        state_q, state_d;
    logic [3:0]    op_q;
    logic [3:0]    cnt_q;
    logic [DW-1:0] acc_q;   // MUL partial product, or DIV/REM partial remainder
    logic [DW-1:0] x_q;     // MUL shifted multiplicand, or DIV dividend/quotient shift register
    logic [DW-1:0] y_q;     // MUL shifted multiplier, or DIV divisor

    logic [3:0]    opcode;
    logic          is_md;
    logic [DW-1:0] alu_res;
    logic [DW:0]   rem_sh;
    logic [DW:0]   rem_sub;
    logic          rem_ge;
    logic          unused_ok;

    assign opcode    = inst_i[DW-1 -: 4];
    assign is_md     = (opcode == OP_MUL) || (opcode == OP_DIV) || (opcode == OP_REM);
    assign unused_ok = ^{inst_addr_i, inst_i[DW-5:AW]};

    // Restoring division step; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    assign rem_sh  = {acc_q, x_q[DW-1]};
    assign rem_ge  = rem_sh >= {1'b0, y_q};
    assign rem_sub = rem_sh - {1'b0, y_q};

    always_comb begin
        alu_res = '0;
        case (opcode)
            OP_ADD:  alu_res = op1_i + op2_i;
            OP_SUB:  alu_res = op1_i - op2_i;
            OP_AND:  alu_res = op1_i & op2_i;
            OP_OR:   alu_res = op1_i | op2_i;
            OP_XOR:  alu_res = op1_i ^ op2_i;
            OP_SLL:  alu_res = op1_i << op2_i[3:0];
            OP_SRL:  alu_res = op1_i >> op2_i[3:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (is_md) begin
                        op_q  <= opcode;
                        cnt_q <= '0;
                        acc_q <= '0;
                        x_q   <= op1_i;
                        y_q   <= op2_i;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (op_q == OP_MUL) begin
                        if (y_q[0]) acc_q <= acc_q + x_q;
                        x_q <= x_q << 1;
                        y_q <= y_q >> 1;
                    end else begin
                        acc_q <= rem_ge ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
                        x_q   <= {x_q[DW-2:0], rem_ge};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_data_o   = '0;
        rd_addr_o   = '0;
        reg_wen_o   = 1'b0;
        jump_en_o   = 1'b0;
        jump_addr_o = '0;
        hold_en_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_md) begin
                    hold_en_o = 1'b1;
                    state_d   = BUSY;
                end else begin
                    case (opcode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
                            rd_data_o = alu_res;
                            rd_addr_o = rd_addr_i;
                            reg_wen_o = reg_wen_i;
                        end
                        OP_BEQ: begin
                            jump_addr_o = inst_i[AW-1:0];
                            jump_en_o   = (op1_i == op2_i);
                        end
                        OP_BNE: begin
                            jump_addr_o = inst_i[AW-1:0];
                            jump_en_o   = (op1_i != op2_i);
                        end
                        OP_JMP: begin
                            jump_addr_o = inst_i[AW-1:0];
                            jump_en_o   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                hold_en_o = 1'b1;
                if (cnt_q == 4'd15) state_d = DONE;
            end
            DONE: begin
                rd_data_o = (op_q == OP_DIV) ? x_q : acc_q;
                rd_addr_o = rd_addr_i;
                reg_wen_o = reg_wen_i;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Outputs follow reset immediately, without waiting for a clock edge.
        if (!rst) begin
            rd_data_o   = '0;
            rd_addr_o   = '0;
            reg_wen_o   = 1'b0;
            jump_en_o   = 1'b0;
            jump_addr_o = '0;
            hold_en_o   = 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed and random instructions, expected retirements queued by the driver
// and checked by an independent monitor on every cycle where hold_en_o is low.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] inst, op1, op2;
    logic [3:0]  iaddr;
    logic [2:0]  rd;
    logic        wen;
    logic [15:0] rd_data_o;
    logic [2:0]  rd_addr_o;
    logic        reg_wen_o, jump_en_o, hold_en_o;
    logic [3:0]  jump_addr_o;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .inst_i(inst), .inst_addr_i(iaddr), .op1_i(op1), .op2_i(op2),
        .rd_addr_i(rd), .reg_wen_i(wen), .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o),
        .reg_wen_o(reg_wen_o), .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o), .hold_en_o(hold_en_o)
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  addr;
        logic        wen;
        logic        jen;
        logic [3:0]  jaddr;
        int          holds;
        logic        chk_addr;
        logic [3:0]  op;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   hold_seen = 0;
    logic mon_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: plain arithmetic on whole operands, one record per retired instruction.
    function automatic exp_t model(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                                   input logic [2:0] r, input logic w);
        exp_t        e;
        logic [31:0] p;
        e = '{data: 16'h0, addr: 3'h0, wen: 1'b0, jen: 1'b0, jaddr: 4'h0, holds: 0, chk_addr: 1'b0, op: i[15:12]};
        case (i[15:12])
            4'h1: e.data = a + b;
            4'h2: e.data = a - b;
            4'h3: e.data = a & b;
            4'h4: e.data = a | b;
            4'h5: e.data = a ^ b;
            4'h6: e.data = a << b[3:0];
            4'h7: e.data = a >> b[3:0];
            4'h8: begin p = {16'h0, a} * {16'h0, b}; e.data = p[15:0]; end
            4'h9: e.data = (b == 16'h0) ? 16'hFFFF : a / b;
            4'hA: e.data = (b == 16'h0) ? a : a % b;
            4'hB: begin e.jaddr = i[3:0]; e.jen = (a == b); end
            4'hC: begin e.jaddr = i[3:0]; e.jen = (a != b); end
            4'hD: begin e.jaddr = i[3:0]; e.jen = 1'b1; end
            default: ;
        endcase
        if (i[15:12] >= 4'h1 && i[15:12] <= 4'hA) begin
            e.wen = w;
            e.addr = r;
            e.chk_addr = 1'b1;
        end
        if (i[15:12] >= 4'h8 && i[15:12] <= 4'hA) e.holds = 17;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the rising edge that follows retirement.
    task automatic issue(input logic [15:0] i, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] r, input logic w);
        int n;
        inst = i; op1 = a; op2 = b; rd = r; wen = w; iaddr = 4'($urandom);
        exp_q.push_back(model(i, a, b, r, w));
        n = 0;
        @(negedge clk);
        while (hold_en_o === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("hold_window_bounded", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && rst) begin
                if (hold_en_o) begin
                    hold_seen++;
                    check("jump_during_hold", 32'(jump_en_o), 32'd0);
                    check("wen_during_hold", 32'(reg_wen_o), 32'd0);
                end else if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: got retirement expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("op%0h_rd_data", e.op), 32'(rd_data_o), 32'(e.data));
                    check($sformatf("op%0h_reg_wen", e.op), 32'(reg_wen_o), 32'(e.wen));
                    check($sformatf("op%0h_jump_en", e.op), 32'(jump_en_o), 32'(e.jen));
                    check($sformatf("op%0h_jump_addr", e.op), 32'(jump_addr_o), 32'(e.jaddr));
                    check($sformatf("op%0h_hold_cycles", e.op), 32'(hold_seen), 32'(e.holds));
                    if (e.chk_addr) check($sformatf("op%0h_rd_addr", e.op), 32'(rd_addr_o), 32'(e.addr));
                    hold_seen = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [3:0]  op;
        logic [15:0] a, b;
        rst = 1'b0; inst = 16'h8000; op1 = 16'h0003; op2 = 16'h0004; rd = 3'h1; wen = 1'b1; iaddr = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_hold", 32'(hold_en_o), 32'd0);
        check("reset_wen", 32'(reg_wen_o), 32'd0);
        check("reset_data", 32'(rd_data_o), 32'd0);
        check("reset_jump", 32'(jump_en_o), 32'd0);
        inst = 16'h0000; op1 = 16'h0; op2 = 16'h0; rd = 3'h0; wen = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("nop_after_reset_hold", 32'(hold_en_o), 32'd0);
        check("nop_after_reset_outs", {rd_data_o, 5'h0, rd_addr_o, 4'h0, jump_addr_o, reg_wen_o, jump_en_o},
              32'd0);
        @(posedge clk); #1;
        hold_seen = 0;
        mon_en = 1'b1;

        issue(16'h1000, 16'hFFFF, 16'h0002, 3'd3, 1'b1);
        issue(16'h6000, 16'h0001, 16'h0013, 3'd2, 1'b1);
        issue(16'hB00A, 16'h1234, 16'h1234, 3'd1, 1'b1);
        issue(16'hC00A, 16'h1234, 16'h1234, 3'd1, 1'b1);
        issue(16'hD005, 16'h0000, 16'h0001, 3'd1, 1'b1);
        issue(16'h8000, 16'h0123, 16'h0010, 3'd4, 1'b1);
        issue(16'h8000, 16'hFFFF, 16'hFFFF, 3'd5, 1'b1);
        issue(16'h9000, 16'd100, 16'd7, 3'd6, 1'b1);
        issue(16'hA000, 16'd100, 16'd7, 3'd7, 1'b1);
        issue(16'h9000, 16'd100, 16'd0, 3'd1, 1'b1);
        issue(16'hA000, 16'd55, 16'd0, 3'd2, 1'b1);
        issue(16'h8000, 16'd3, 16'd4, 3'd3, 1'b1);
        issue(16'h8000, 16'd5, 16'd6, 3'd4, 1'b1);
        issue(16'hE000, 16'h1111, 16'h2222, 3'd5, 1'b1);

        for (int k = 0; k < 80; k++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 16'h0;
                default: b = 16'($urandom);
            endcase
            issue({op, 12'($urandom)}, a, b, 3'($urandom), 1'($urandom));
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;

        // Abort a MUL mid-flight: issue cycle, then BUSY with count 0..7.
        inst = 16'h8000; op1 = 16'h00FF; op2 = 16'h00FF; rd = 3'd6; wen = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_mul_busy_hold", 32'(hold_en_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("abort_hold_drops", 32'(hold_en_o), 32'd0);
        check("abort_no_write", 32'(reg_wen_o), 32'd0);
        inst = 16'h0000;
        @(posedge clk); #1 rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("post_abort_idle_hold", 32'(hold_en_o), 32'd0);
            check("post_abort_no_write", 32'(reg_wen_o), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
